// File: rtl/reg_file_sb.sv
// RV32I register file with busy scoreboard and hardware clear sequencer.
// Optional same-cycle write-to-read bypass: define RF_WR_BYPASS_EN.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  output logic                   rf_ready,
  output logic                   drop_err
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [ADDR_W-1:0] clr_idx_d;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              drop_q;
  logic              drop_d;
  logic              ready;
  logic              clr_go;
  logic              wr_ok;
  logic              iss_ok;

  logic [XLEN-1:0] rf [NREG];

  always_comb begin
    ready  = (state_q == READY);
    clr_go = ready && clr_req;
    wr_ok  = ready && !clr_req && wr_en
             && (wr_addr != '0);
    iss_ok = ready && !clr_req && iss_valid
             && (iss_rd != '0);
    drop_d = (wr_en || iss_valid)
             && (!ready || clr_req);
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // a new producer issued on the writeback edge keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (clr_go) begin
      busy_d = '0;
    end else begin
      if (wr_ok)  busy_d[wr_addr] = 1'b0;
      if (iss_ok) busy_d[iss_rd]  = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      rf[clr_idx_q] <= '0;
    end else if (wr_ok) begin
      rf[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0]   d;
    logic              b;

    assign a = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (ready && (a != '0)) begin
        d = rf[a];
        b = busy_q[a];
`ifdef RF_WR_BYPASS_EN
        if (wr_en && (wr_addr == a)) begin
          d = wr_data;
          b = iss_valid && (iss_rd == a);
        end
`endif
      end
    end

    assign rd_data[p*XLEN +: XLEN] = d;
    assign rd_busy[p]              = b;
  end

  assign rf_ready = ready;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations queued with stimulus,
// drained against DUT outputs between clock edges.
module tb_reg_file_sb;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  localparam int S_D0  = 0;
  localparam int S_D1  = 1;
  localparam int S_B0  = 2;
  localparam int S_B1  = 3;
  localparam int S_RDY = 4;
  localparam int S_DRP = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clr_req = 1'b0;
  logic                  wr_en = 1'b0;
  logic [ADDR_W-1:0]     wr_addr = '0;
  logic [XLEN-1:0]       wr_data = '0;
  logic                  iss_valid = 1'b0;
  logic [ADDR_W-1:0]     iss_rd = '0;
  logic [NRD*ADDR_W-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  rf_ready;
  logic                  drop_err;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  reg_file_sb #(
    .XLEN  (XLEN),
    .ADDR_W(ADDR_W),
    .NRD   (NRD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rf_ready (rf_ready),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic push(input string tag,
                      input int sel,
                      input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_D0:    return rd_data[0 +: XLEN];
      S_D1:    return rd_data[XLEN +: XLEN];
      S_B0:    return {31'd0, rd_busy[0]};
      S_B1:    return {31'd0, rd_busy[1]};
      S_RDY:   return {31'd0, rf_ready};
      default: return {31'd0, drop_err};
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0,
                        input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    iss_valid = 1'b0;
    clr_req   = 1'b0;
  endtask

  initial begin
    #12;
    rst_n = 1'b1;

    // power-on clear: 32 edges after release
    for (int k = 1; k <= 32; k++) begin
      set_rd(ADDR_W'(k), ADDR_W'(k + 7));
      edge_step();
      push("por_rdy", S_RDY, (k == 32) ? 1 : 0);
      push("por_d0", S_D0, 0);
      push("por_d1", S_D1, 0);
      drain();
    end

    // write x5, read back
    wr_en = 1'b1; wr_addr = 5;
    wr_data = 32'hDEADBEEF;
    edge_step();
    idle();
    set_rd(5, 0);
    push("x5_p0", S_D0, 32'hDEADBEEF);
    push("x0_p1", S_D1, 0);
    drain();

    // write to x0 discarded, no drop
    wr_en = 1'b1; wr_addr = 0;
    wr_data = 32'h1234;
    edge_step();
    idle();
    set_rd(0, 5);
    push("x0_wr_p0", S_D0, 0);
    push("x0_wr_p1", S_D1, 32'hDEADBEEF);
    push("x0_wr_drop", S_DRP, 0);
    drain();

    // issue x7 then writeback
    iss_valid = 1'b1; iss_rd = 7;
    edge_step();
    idle();
    set_rd(7, 0);
    push("x7_busy", S_B0, 1);
    push("x0_busy", S_B1, 0);
    drain();

    wr_en = 1'b1; wr_addr = 7;
    wr_data = 32'h55;
    edge_step();
    idle();
    push("x7_unbusy", S_B0, 0);
    push("x7_data", S_D0, 32'h55);
    drain();

    // same-edge issue and write: busy wins
    wr_en = 1'b1; wr_addr = 9;
    wr_data = 32'h99;
    iss_valid = 1'b1; iss_rd = 9;
    edge_step();
    idle();
    set_rd(7, 9);
    push("x9_busy", S_B1, 1);
    push("x9_data", S_D1, 32'h99);
    drain();

    // clear request with a colliding write
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 3;
    wr_data = 32'hAA;
    edge_step();
    idle();
    push("clr_drop", S_DRP, 1);
    push("clr_rdy", S_RDY, 0);
    push("clr_busy", S_B1, 0);
    drain();
    for (int k = 1; k <= 32; k++) begin
      edge_step();
      if (k == 1) push("clr_drop_once", S_DRP, 0);
      push("clr_rdy_k", S_RDY, (k == 32) ? 1 : 0);
      drain();
    end
    set_rd(3, 5);
    push("x3_cleared", S_D0, 0);
    push("x5_cleared", S_D1, 0);
    drain();
    set_rd(9, 7);
    push("x9_busy_clr", S_B0, 0);
    push("x7_cleared", S_D1, 0);
    drain();

    // reset in the middle of a clear
    wr_en = 1'b1; wr_addr = 6;
    wr_data = 32'h66;
    edge_step();
    idle();
    clr_req = 1'b1;
    edge_step();
    idle();
    for (int k = 0; k < 10; k++) edge_step();
    rst_n = 1'b0;
    push("rst_rdy", S_RDY, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      iss_valid = (k == 5);
      iss_rd    = 12;
      edge_step();
      iss_valid = 1'b0;
      push("rst_rdy_k", S_RDY, (k == 32) ? 1 : 0);
      push("clr_iss_drop", S_DRP, (k == 5) ? 1 : 0);
      drain();
    end
    set_rd(6, 12);
    push("x6_cleared", S_D0, 0);
    push("x12_not_busy", S_B1, 0);
    drain();

    // same-cycle write and read of x4
    wr_en = 1'b1; wr_addr = 4;
    wr_data = 32'h0F0F0F0F;
    set_rd(0, 4);
`ifdef RF_WR_BYPASS_EN
    push("x4_same", S_D1, 32'h0F0F0F0F);
`else
    push("x4_same", S_D1, 0);
`endif
    push("x4_same_busy", S_B1, 0);
    drain();
    edge_step();
    idle();
    push("x4_next", S_D1, 32'h0F0F0F0F);
    push("x4_drop", S_DRP, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the RV32I core family.
- Features:
  - NRD asynchronous read ports and one synchronous write port.
  - x0 hardwired to zero.
  - Per-register busy scoreboard for pending writebacks.
  - Hardware clear sequencer that zeroes storage after reset or on request.
- Sits between decode (read and issue) and writeback (write), replacing simulation-only initialisation with a synthesisable clear.

Parameters:
- XLEN, 32, data width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NRD, 2, number of read ports (1..4).

Ports:
- clk  input  1  global clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_req  input  1  request a full storage clear; sampled in READY only.
- wr_en  input  1  write enable from writeback.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  XLEN  write data.
- iss_valid  input  1  an instruction writing iss_rd was issued this cycle.
- iss_rd  input  ADDR_W  destination register of the issued instruction.
- rd_addr  input  NRD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data  output  NRD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
- rd_busy  output  NRD  port p's register has a pending write.
- rf_ready  output  1  storage valid; high in READY state.
- drop_err  output  1  one-cycle pulse when a write or issue is dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_idx=0, all busy bits=0.
  - rf_ready=0, drop_err=0.
  - Storage array has no reset; it is zeroed by CLEAR.
- State CLEAR:
  - Each rising edge: rf[clr_idx]<=0 and clr_idx increments.
  - On the edge where clr_idx==NREG-1 is written: state<=READY and clr_idx<=0.
  - rf_ready is first high after the NREG-th rising edge following rst_n release (32 edges by default).
- In CLEAR, for inputs and outputs:
  - rd_data forced to 0 on all ports; rd_busy forced to 0.
  - wr_en or iss_valid high: operation ignored; drop_err=1 on the next cycle (registered).
  - clr_req ignored.
- State READY:
  - clr_req=1: state<=CLEAR, clr_idx<=0, all busy<=0, rf_ready<=0 at the same edge.
  - Any simultaneous wr_en or iss_valid in that cycle is dropped and raises drop_err.
- Write (READY, wr_en=1, wr_addr!=0):
  - rf[wr_addr]<=wr_data at the rising edge; busy[wr_addr]<=0.
  - A write to x0 is discarded silently; no drop_err.
- Issue (READY, iss_valid=1, iss_rd!=0):
  - busy[iss_rd]<=1.
  - iss_rd==0 is ignored.
  - Same edge as a write to the same address: set wins, busy stays 1 (new producer).
- Reads:
  - Combinational.
  - rd_data = 0 if the port address is 0, else rf[addr].
  - rd_busy = 0 if the port address is 0, else busy[addr].
  - Without the optional feature, a same-cycle write is not visible until after the edge.
- Ports are independent; multiple ports may read the same address.
- busy[0] is constant 0.
- drop_err is registered: high exactly one cycle after the offending cycle, otherwise 0.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined: when READY, wr_en=1 and wr_addr==rd addr (addr!=0) for a port:
  - That port's rd_data=wr_data in the same cycle.
  - That port's rd_busy=0 unless busy is being re-set by a same-cycle iss_valid to that address (then 1).
- Undefined: rd_data is the stored value and rd_busy is the registered busy bit only.
- The CLEAR-state forcing to 0 overrides the bypass in both builds.

Test Plan:
- Release rst_n, read every address during CLEAR:
  - rd_data=0, rf_ready=0 for 31 edges.
  - rf_ready=1 after edge 32.
  - All reads 0.
- READY; write x5=0xDEADBEEF; next cycle rd_addr port0=5, port1=0:
  - port0=0xDEADBEEF, port1=0.
  - Write x0=0x1234 → x0 still reads 0, no drop_err.
- iss_valid iss_rd=7 → rd_busy[7]=1 next cycle.
- Then wr_en x7=0x55 → busy clears, rd_data=0x55.
- Same-cycle iss and write to x9 → busy stays 1.
- Assert clr_req with simultaneous wr_en x3=0xAA:
  - drop_err pulses once.
  - rf_ready low for 32 cycles; busy bits cleared.
  - x3 and x5 read 0 afterwards.
- Pull rst_n low mid-CLEAR (clr_idx=10) and release:
  - Clear restarts at 0.
  - rf_ready returns exactly 32 edges after release.
- With RF_WR_BYPASS_EN: write x4=0x0F0F0F0F while port1 reads x4 in the same cycle → rd_data port1=0x0F0F0F0F combinationally.
- Without RF_WR_BYPASS_EN, same stimulus → old value 0, then 0x0F0F0F0F next cycle.
